// File: rtl/qq_pkg.sv
// rtl/qq_pkg.sv - shared QuickQ key defaults and the enq/deq command encoding
package qq_pkg;

   localparam int QQ_W_DEF = 32;
   localparam int QQ_D_DEF = 4;

   // Bit order is {enq, deq}, matching the node FSM's enq_o/deq_o pair.
   typedef enum logic [1:0] {
      CMD_HOLD = 2'b00,
      CMD_REM  = 2'b01,
      CMD_INS  = 2'b10,
      CMD_REP  = 2'b11
   } qq_cmd_e;

endpackage

// File: rtl/qq_tail_cell.sv
// rtl/qq_tail_cell.sv - one sorted key slot of the tail buffer
module qq_tail_cell
   import qq_pkg::*;
#(
   parameter int          W       = QQ_W_DEF,
   parameter logic [W-1:0] MAX_KEY = {W{1'b1}},
   parameter bit          FIRST   = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_gt,
   input  logic         i_below_gt,
   input  logic         i_above_gt,
   input  logic [W-1:0] i_below,
   input  logic [W-1:0] i_above,
   input  logic [W-1:0] i_new,
   input  logic [1:0]   i_cmd,
   output logic [W-1:0] o_key
);

   logic [W-1:0] r_key;
   logic [W-1:0] w_next;
   logic         w_keep_own;

   // On replace the array first shifts down, so slot 0's own key is gone;
   // every other slot's own key becomes the "below" neighbour of the shifted view.
   assign w_keep_own = i_gt & ~FIRST;

   always_comb begin
      w_next = r_key;
      case (qq_cmd_e'(i_cmd))
         CMD_INS: begin
            if (i_below_gt)
               w_next = i_below;
            else if (i_gt)
               w_next = i_new;
         end
         CMD_REM: w_next = i_above;
         CMD_REP: begin
            if (!i_above_gt)
               w_next = i_above;
            else if (!w_keep_own)
               w_next = i_new;
         end
         default: w_next = r_key;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_key <= MAX_KEY;
      else
         r_key <= w_next;
   end

   assign o_key = r_key;

endmodule

// File: rtl/qq_tail.sv
// rtl/qq_tail.sv - right-end terminator and sorted spill buffer of a QuickQ chain
module qq_tail
   import qq_pkg::*;
#(
   parameter int           W       = QQ_W_DEF,
   parameter int           D       = QQ_D_DEF,
   parameter logic [W-1:0] MAX_KEY = {W{1'b1}}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enq_i,
   input  logic [W-1:0]           data_lt_i,
   input  logic                   deq_i,
   output logic [W-1:0]           data_rt_o,
   output logic [$clog2(D+1)-1:0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf,
   input  logic                   clr_ovf
);

   localparam int             CW       = $clog2(D+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(D);

   logic [W-1:0]  w_slot [D];
   logic [D-1:0]  w_gt;
   logic          w_key_max;
   logic          w_full;
   logic          w_empty;
   qq_cmd_e       w_cmd;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   assign w_key_max = (data_lt_i == MAX_KEY);
   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);

   // A MAX_KEY insert is a no-op, so replace with it degenerates to remove.
   always_comb begin
      w_cmd = qq_cmd_e'({enq_i, deq_i});
      if (w_key_max) begin
         if (w_cmd == CMD_INS)
            w_cmd = CMD_HOLD;
         else if (w_cmd == CMD_REP)
            w_cmd = CMD_REM;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : g_cell
         logic [W-1:0] w_below;
         logic [W-1:0] w_above;
         logic         w_below_gt;
         logic         w_above_gt;

         assign w_gt[gi] = (w_slot[gi] > data_lt_i);

         if (gi == 0) begin : g_lo
            assign w_below    = MAX_KEY;
            assign w_below_gt = 1'b0;
         end else begin : g_mid_lo
            assign w_below    = w_slot[gi-1];
            assign w_below_gt = w_gt[gi-1];
         end

         if (gi == D-1) begin : g_hi
            assign w_above    = MAX_KEY;
            assign w_above_gt = 1'b1;
         end else begin : g_mid_hi
            assign w_above    = w_slot[gi+1];
            assign w_above_gt = w_gt[gi+1];
         end

         qq_tail_cell #(
            .W       (W),
            .MAX_KEY (MAX_KEY),
            .FIRST   (gi == 0)
         ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .i_gt       (w_gt[gi]),
            .i_below_gt (w_below_gt),
            .i_above_gt (w_above_gt),
            .i_below    (w_below),
            .i_above    (w_above),
            .i_new      (data_lt_i),
            .i_cmd      (w_cmd),
            .o_key      (w_slot[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (w_cmd)
            CMD_INS: if (!w_full)  r_count <= r_count + 1'b1;
            CMD_REM: if (!w_empty) r_count <= r_count - 1'b1;
            CMD_REP: if (w_empty)  r_count <= r_count + 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_cmd == CMD_INS && w_full)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
      end
   end

   assign data_rt_o = w_slot[0];
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign ovf       = r_ovf;

endmodule

// File: doc/qq_tail.md
Name: qq_tail

Overview:
- Right-end terminator and spill buffer for a QuickQ node chain.
- Responds to the last node's enqueue-right and dequeue-right pulses:
  - absorbs keys evicted rightward;
  - always presents its smallest key back to the left on data_rt_o.
- Holds a small sorted register array; completes every operation in one cycle, so the left node never waits.

Parameters:
- W, 32, key width in bits.
- D, 4, number of key slots held.
- MAX_KEY, all-ones of W, sentinel meaning "empty slot".

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enq_i  in  1  one-cycle pulse from left node's enq_o: insert data_lt_i.
- data_lt_i  in  W  key being pushed right; valid when enq_i=1.
- deq_i  in  1  one-cycle pulse from left node's deq_o: remove current minimum.
- data_rt_o  out  W  current minimum key (slot 0); MAX_KEY when empty.
- count  out  $clog2(D+1)  number of valid keys held.
- full  out  1  count==D.
- empty  out  1  count==0.
- ovf  out  1  sticky: a key was dropped because the buffer was full.
- clr_ovf  in  1  clears ovf.

Behaviour:
- Clock and reset: one clock clk; rst synchronous active-high.
- Reset values:
  - all slots=MAX_KEY, count=0, empty=1, full=0, ovf=0;
  - data_rt_o=MAX_KEY the cycle after reset.
- Storage order: slots 0..D-1 kept sorted ascending; valid keys packed at low indices, MAX_KEY above.
- data_rt_o: driven combinationally from slot 0 (zero latency). The left node samples it in the same cycle deq_i is high.
- Operation encoding (enq_i, deq_i):
  - 00: hold.
  - 10, insert:
    - Compute insertion index k = number of valid slots with key <= data_lt_i. Ties go after existing equals, giving FIFO order among equal keys.
    - Slots k..D-2 shift up one; slot k takes data_lt_i; count+1.
  - 01, remove:
    - Slots 1..D-1 shift down; slot D-1 takes MAX_KEY; count-1.
  - 11, replace:
    - Remove the minimum and insert data_lt_i in the same cycle.
    - Result equals remove followed by insert; count unchanged.
    - data_rt_o in this cycle is the old minimum.
- All updates are visible on data_rt_o/count/full/empty the next cycle (1-cycle latency).
- Boundary conditions:
  - Insert while full (no deq):
    - Compare data_lt_i with slot D-1; the larger is dropped, the smaller is placed sorted.
    - count stays D; ovf<=1.
  - Insert of data_lt_i==MAX_KEY: ignored, no count change, no ovf.
  - Remove while empty: no state change; count stays 0; data_rt_o stays MAX_KEY.
  - Replace while empty: behaves as insert.
  - clr_ovf and a same-cycle overflow: set wins, ovf=1.
  - Reset mid-operation: reset wins over all inputs; the held contents are discarded.
- Counter: count saturates at 0 and D and never wraps. full and empty are registered-equivalent, i.e. derived from count only.
- No FSM states beyond the register array. The operation select is a 2-bit decoded command (HOLD, INS, REM, REP), one per cycle.

Decomposition:
- qq_pkg:
  - MAX_KEY default;
  - the typedef for the command enum (HOLD=2'b00, INS=2'b10, REM=2'b01, REP=2'b11), shared with the node FSM for enq/deq encoding.
- Sub-module qq_tail_cell, one slot:
  - holds a key;
  - inputs: own-greater compare result, neighbour-below key, neighbour-above key, new key, command;
  - selects hold / take-new / shift-up / shift-down;
  - instanced D times by generate.

Test Plan (W=8, D=4, MAX_KEY=8'hFF):
- Reset, then 3 idle cycles -> data_rt_o=FF, count=0, empty=1, full=0, ovf=0.
- enq 40, 10, 30 on consecutive cycles -> slots {10,30,40,FF}, data_rt_o=10, count=3.
- From {10,30,40,FF}: deq_i pulse -> data_rt_o=10 during the pulse, then 30; count=2; slot 3=FF.
- Fill to {10,20,30,40}, enq 25 -> slots {10,20,25,30}, 40 dropped, ovf=1, full=1; then clr_ovf -> ovf=0.
- Fill to {10,20,30,40}, enq 50 -> 50 dropped, contents unchanged, ovf=1.
- From {10,30,FF,FF}, enq_i=deq_i=1 with 20:
  - data_rt_o=10 in that cycle;
  - next {20,30,FF,FF}, count=2.
- Edge inputs:
  - deq on empty -> no change;
  - enq FF -> ignored;
  - enq 30 twice -> second 30 lands above the first;
  - rst asserted mid-burst -> all FF next cycle.
